// File: rtl/sc_io_arbiter.sv
// Two-port round-robin arbiter and bus-cycle sequencer for the SCOMP-style I/O bus.
// Each transfer runs SETUP, ACTIVE (CYC_LEN cycles), DONE, then an optional turnaround.
module sc_io_arbiter #(
    parameter int CYC_LEN  = 4,
    parameter int TURN_LEN = 1
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic [1:0]  i_req,
    input  logic [1:0]  i_we,
    input  logic [7:0]  i_addr0,
    input  logic [7:0]  i_addr1,
    input  logic [15:0] i_wdata0,
    input  logic [15:0] i_wdata1,
    output logic [1:0]  o_ack,
    output logic [15:0] o_rdata,
    output logic        o_busy,
    output logic        o_sc_iocyc,
    output logic        o_sc_iowr,
    output logic [7:0]  o_sc_ioaddr,
    output logic [15:0] o_sc_dout,
    output logic        o_sc_dout_oe,
    input  logic [15:0] i_sc_din
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] SETUP  = 3'd1;
    localparam logic [2:0] ACTIVE = 3'd2;
    localparam logic [2:0] DONE   = 3'd3;
    localparam logic [2:0] TURN   = 3'd4;

    localparam logic [3:0] ACT_LOAD  = 4'(CYC_LEN - 1);
    localparam int         TURN_INIT = (TURN_LEN > 0) ? (TURN_LEN - 1) : 0;
    localparam logic [2:0] TURN_LOAD = 3'(TURN_INIT);
    localparam logic [2:0] DONE_NEXT = (TURN_LEN > 0) ? TURN : IDLE;

    logic [2:0]  state;
    logic [3:0]  act_cnt;
    logic [2:0]  turn_cnt;
    logic        grant;
    logic        last_grant;
    logic        pick;
    logic [7:0]  lat_addr;
    logic        lat_we;
    logic [15:0] lat_wdata;
    logic        in_xfer;
    logic        drive_wr;

    // On contention the port that did not win last time gets the bus
    always_comb begin
        pick = 1'b0;
        if (i_req[0] && i_req[1])
            pick = ~last_grant;
        else
            pick = ~i_req[0];
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state      <= IDLE;
            act_cnt    <= 4'd0;
            turn_cnt   <= 3'd0;
            grant      <= 1'b0;
            last_grant <= 1'b1;
            o_rdata    <= 16'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (|i_req) begin
                        state <= SETUP;
                        grant <= pick;
                    end
                end
                SETUP: begin
                    state   <= ACTIVE;
                    act_cnt <= ACT_LOAD;
                end
                ACTIVE: begin
                    if (act_cnt == 4'd0) begin
                        state <= DONE;
                        if (!lat_we)
                            o_rdata <= i_sc_din;
                    end else begin
                        act_cnt <= act_cnt - 4'd1;
                    end
                end
                DONE: begin
                    last_grant <= grant;
                    state      <= DONE_NEXT;
                    turn_cnt   <= TURN_LOAD;
                end
                TURN: begin
                    if (turn_cnt == 3'd0)
                        state <= IDLE;
                    else
                        turn_cnt <= turn_cnt - 3'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Request snapshot; only meaningful while a transfer is in flight, so no reset
    always_ff @(posedge i_clk) begin
        if (state == IDLE && (|i_req)) begin
            lat_addr  <= pick ? i_addr1 : i_addr0;
            lat_we    <= pick ? i_we[1] : i_we[0];
            lat_wdata <= pick ? i_wdata1 : i_wdata0;
        end
    end

    always_comb begin
        in_xfer      = (state == SETUP) || (state == ACTIVE) || (state == DONE);
        drive_wr     = in_xfer && lat_we;
        o_busy       = (state != IDLE);
        o_sc_iocyc   = (state == ACTIVE);
        o_sc_iowr    = drive_wr;
        o_sc_dout_oe = drive_wr;
        o_sc_ioaddr  = in_xfer ? lat_addr : 8'd0;
        o_sc_dout    = drive_wr ? lat_wdata : 16'd0;
        o_ack        = 2'b00;
        if (state == DONE)
            o_ack = grant ? 2'b10 : 2'b01;
    end

endmodule

// File: tb/tb_sc_io_arbiter.sv
// Directed bench for sc_io_arbiter: write, read, contention, zero turnaround,
// reset abort and mid-transfer request drop.
module tb_sc_io_arbiter;

    logic        clk;
    logic        reset_n;
    logic        reset_n_b;
    logic [1:0]  req;
    logic [1:0]  req_b;
    logic [1:0]  we;
    logic [7:0]  addr0, addr1;
    logic [15:0] wdata0, wdata1;
    logic [15:0] din;

    logic [1:0]  ack, ack_b;
    logic [15:0] rdata, rdata_b;
    logic        busy, busy_b;
    logic        iocyc, iocyc_b;
    logic        iowr, iowr_b;
    logic [7:0]  ioaddr, ioaddr_b;
    logic [15:0] dout, dout_b;
    logic        oe, oe_b;

    int n_checks = 0;
    int n_fails  = 0;

    sc_io_arbiter #(.CYC_LEN(4), .TURN_LEN(1)) dut (
        .i_clk(clk), .i_reset_n(reset_n), .i_req(req), .i_we(we),
        .i_addr0(addr0), .i_addr1(addr1), .i_wdata0(wdata0), .i_wdata1(wdata1),
        .o_ack(ack), .o_rdata(rdata), .o_busy(busy), .o_sc_iocyc(iocyc),
        .o_sc_iowr(iowr), .o_sc_ioaddr(ioaddr), .o_sc_dout(dout),
        .o_sc_dout_oe(oe), .i_sc_din(din)
    );

    sc_io_arbiter #(.CYC_LEN(4), .TURN_LEN(0)) dut_t0 (
        .i_clk(clk), .i_reset_n(reset_n_b), .i_req(req_b), .i_we(we),
        .i_addr0(addr0), .i_addr1(addr1), .i_wdata0(wdata0), .i_wdata1(wdata1),
        .o_ack(ack_b), .o_rdata(rdata_b), .o_busy(busy_b), .o_sc_iocyc(iocyc_b),
        .o_sc_iowr(iowr_b), .o_sc_ioaddr(ioaddr_b), .o_sc_dout(dout_b),
        .o_sc_dout_oe(oe_b), .i_sc_din(din)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic act_e, xfer_e;

        reset_n = 1'b0; reset_n_b = 1'b0;
        req = 2'b00; req_b = 2'b00; we = 2'b00;
        addr0 = 8'h00; addr1 = 8'h00; wdata0 = 16'h0; wdata1 = 16'h0; din = 16'hDEAD;
        tick(); tick();

        check("rst_ack", 32'(ack), 32'h0);
        check("rst_rdata", 32'(rdata), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_iocyc", 32'(iocyc), 32'h0);
        check("rst_oe", 32'(oe), 32'h0);
        check("rst_ioaddr", 32'(ioaddr), 32'h0);
        check("rst_dout", 32'(dout), 32'h0);
        check("rst_iowr", 32'(iowr), 32'h0);

        // Port 0 write, 0xBEEF to 0x12
        reset_n = 1'b1;
        req = 2'b01; we = 2'b01; addr0 = 8'h12; wdata0 = 16'hBEEF; addr1 = 8'h66;
        check("wr_c0_busy", 32'(busy), 32'h0);
        for (int c = 1; c <= 8; c++) begin
            tick();
            act_e  = (c >= 2 && c <= 5);
            xfer_e = (c >= 1 && c <= 6);
            check("wr_iocyc", 32'(iocyc), 32'(act_e));
            check("wr_oe", 32'(oe), 32'(xfer_e));
            check("wr_iowr", 32'(iowr), 32'(xfer_e));
            check("wr_ioaddr", 32'(ioaddr), xfer_e ? 32'h12 : 32'h0);
            check("wr_dout", 32'(dout), xfer_e ? 32'hBEEF : 32'h0);
            check("wr_ack", 32'(ack), (c == 6) ? 32'h1 : 32'h0);
            check("wr_busy", 32'(busy), (c <= 7) ? 32'h1 : 32'h0);
            if (c == 6) begin
                check("wr_rdata_kept", 32'(rdata), 32'h0);
                req = 2'b00;
            end
        end

        // Port 1 read of 0x05; pad carries 0x1234 only in cycle 5
        req = 2'b10; we = 2'b00; addr1 = 8'h05; addr0 = 8'h77; din = 16'hDEAD;
        for (int c = 1; c <= 8; c++) begin
            tick();
            din = (c == 5) ? 16'h1234 : 16'hDEAD;
            xfer_e = (c >= 1 && c <= 6);
            check("rd_oe", 32'(oe), 32'h0);
            check("rd_iowr", 32'(iowr), 32'h0);
            check("rd_ioaddr", 32'(ioaddr), xfer_e ? 32'h05 : 32'h0);
            check("rd_iocyc", 32'(iocyc), (c >= 2 && c <= 5) ? 32'h1 : 32'h0);
            check("rd_ack", 32'(ack), (c == 6) ? 32'h2 : 32'h0);
            if (c >= 6) check("rd_rdata", 32'(rdata), 32'h1234);
            if (c == 6) req = 2'b00;
        end

        // Both ports request continuously from reset
        reset_n = 1'b0;
        tick();
        req = 2'b11; we = 2'b11; addr0 = 8'h12; addr1 = 8'h05;
        reset_n = 1'b1;
        for (int c = 1; c <= 32; c++) begin
            tick();
            check("rr_ack", 32'(ack),
                  (c == 6 || c == 22) ? 32'h1 : ((c == 14 || c == 30) ? 32'h2 : 32'h0));
            if (c == 1 || c == 17) check("rr_addr_p0", 32'(ioaddr), 32'h12);
            if (c == 9 || c == 25) check("rr_addr_p1", 32'(ioaddr), 32'h05);
        end
        req = 2'b00;

        // Zero-turnaround instance: port 0 back-to-back
        reset_n_b = 1'b1;
        req_b = 2'b01; we = 2'b01; addr0 = 8'h12; wdata0 = 16'hBEEF;
        for (int c = 1; c <= 9; c++) begin
            tick();
            check("t0_busy", 32'(busy_b), (c == 7) ? 32'h0 : 32'h1);
            check("t0_iocyc", 32'(iocyc_b), ((c >= 2 && c <= 5) || c == 9) ? 32'h1 : 32'h0);
            check("t0_ack", 32'(ack_b), (c == 6) ? 32'h1 : 32'h0);
            if (c == 8) check("t0_setup_addr", 32'(ioaddr_b), 32'h12);
        end
        req_b = 2'b00;
        reset_n_b = 1'b0;

        // Reset during cycle 3 of a port 0 write
        tick();
        req = 2'b01; we = 2'b01; addr0 = 8'h12; wdata0 = 16'hBEEF;
        tick(); tick(); tick();
        check("ab_iocyc_pre", 32'(iocyc), 32'h1);
        reset_n = 1'b0;
        #1;
        check("ab_iocyc", 32'(iocyc), 32'h0);
        check("ab_oe", 32'(oe), 32'h0);
        check("ab_ioaddr", 32'(ioaddr), 32'h0);
        check("ab_dout", 32'(dout), 32'h0);
        check("ab_busy", 32'(busy), 32'h0);
        req = 2'b00;
        tick();
        check("ab_ack_rst", 32'(ack), 32'h0);
        reset_n = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            tick();
            check("ab_ack_after", 32'(ack), 32'h0);
            check("ab_busy_after", 32'(busy), 32'h0);
        end
        req = 2'b10; we = 2'b00; addr1 = 8'h05; din = 16'hA5A5;
        for (int c = 1; c <= 8; c++) begin
            tick();
            check("ab_p1_ack", 32'(ack), (c == 6) ? 32'h2 : 32'h0);
            if (c == 6) begin
                check("ab_p1_rdata", 32'(rdata), 32'hA5A5);
                req = 2'b00;
            end
        end

        // Port 1 write, request dropped in cycle 3
        req = 2'b10; we = 2'b10; addr1 = 8'h34; wdata1 = 16'h5678;
        for (int c = 1; c <= 11; c++) begin
            tick();
            if (c == 3) req = 2'b00;
            check("dr_ack", 32'(ack), (c == 6) ? 32'h2 : 32'h0);
            check("dr_busy", 32'(busy), (c <= 7) ? 32'h1 : 32'h0);
            check("dr_dout", 32'(dout), (c <= 6) ? 32'h5678 : 32'h0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/sc_io_arbiter.md
# sc_io_arbiter

Shares the SCOMP-style 8-bit-address / 16-bit-data I/O bus between two requesters (port 0: Wishbone bridge side, port 1: debug/DMA side) and sequences each bus cycle. It does round-robin arbitration, generates setup/strobe/turnaround timing, drives write data with an output enable, and captures read data. It sits between the Wishbone-to-SCOMP translation logic and the top-level tristate pad for the I/O data bus.

## Interface
- CYC_LEN, 4, cycles `o_sc_iocyc` stays high per transfer; legal range 2–15.
- TURN_LEN, 1, idle turnaround cycles after each transfer; legal range 0–7.

- i_clk  in  1  system clock, all logic on rising edge.
- i_reset_n  in  1  asynchronous active-low reset.
- i_req  in  2  per-port request; must be held high until the matching `o_ack`.
- i_we  in  2  per-port write enable (1 = write), valid while `i_req`.
- i_addr0, i_addr1  in  8 each  per-port I/O address.
- i_wdata0, i_wdata1  in  16 each  per-port write data.
- o_ack  out  2  one-cycle completion pulse, one-hot.
- o_rdata  out  16  read data, valid in the `o_ack` cycle and held until the next read completes.
- o_busy  out  1  high in any state other than IDLE.
- o_sc_iocyc  out  1  I/O cycle strobe.
- o_sc_iowr  out  1  1 = write cycle.
- o_sc_ioaddr  out  8  I/O address.
- o_sc_dout  out  16  write data to the pad.
- o_sc_dout_oe  out  1  pad output enable.
- i_sc_din  in  16  data from the pad.

## Operation
- States:
  - IDLE → SETUP when any `i_req` bit is high.
  - SETUP (1 cycle) → ACTIVE.
  - ACTIVE (CYC_LEN cycles) → DONE.
  - DONE (1 cycle) → TURN if TURN_LEN > 0, else IDLE.
  - TURN (TURN_LEN cycles) → IDLE.
- Arbitration happens only in IDLE:
  - One request pending: that port wins.
  - Both pending: the port not equal to `last_grant` wins.
  - `last_grant` resets to 1, so port 0 wins the first contention.
- On leaving IDLE, the winner's addr, we and wdata are latched into internal registers. Requester inputs are ignored until the next IDLE.
- `o_sc_ioaddr` and `o_sc_iowr` are driven from the latched values during SETUP, ACTIVE and DONE. They are 0 in all other states.
- `o_sc_iocyc` is high only in ACTIVE.
- Write cycles:
  - `o_sc_dout_oe` is high in SETUP, ACTIVE and DONE.
  - `o_sc_dout` equals the latched wdata in those states and 0 otherwise.
- Read cycles:
  - `o_sc_dout_oe` stays 0.
  - `i_sc_din` is sampled into `o_rdata` on the last ACTIVE cycle.
  - Writes leave `o_rdata` unchanged.
- In DONE, `o_ack[grant]` pulses and `last_grant` updates to the granted port.
- If a requester drops `i_req` mid-transfer, the transfer still completes and the ack still pulses.
- The ACTIVE counter is 4 bits and the TURN counter is 3 bits. Both reload on entry to their state; no wrap-around is possible within the legal ranges.

## Timing
- Reset (asynchronous, immediate) sets:
  - state = IDLE, `last_grant` = 1;
  - all outputs 0, including `o_rdata`, `o_sc_dout_oe` and `o_ack`.
- Reset mid-transfer aborts the transfer with no ack and releases the pad at once.
- With the request seen high in IDLE at cycle 0:
  - SETUP is cycle 1.
  - ACTIVE is cycles 2 … CYC_LEN+1.
  - `o_ack` is high in cycle CYC_LEN+2.
- Earliest re-grant is the IDLE cycle CYC_LEN+3+TURN_LEN. The same port can therefore issue back-to-back requests every CYC_LEN+3+TURN_LEN cycles.
- A request raised during a transfer waits, with no loss, until the next IDLE.
- A request and the ack for the other port in the same cycle causes no conflict: the new request is arbitrated in the following IDLE.
- `o_busy` is combinational from state. All other outputs are registered or decoded directly from the state register, with no paths from requester inputs to outputs.

## Test plan
- Port 0 write, addr 0x12, data 0xBEEF, CYC_LEN=4, TURN_LEN=1:
  - iocyc high in cycles 2–5, iowr=1, oe high in cycles 1–6, ioaddr=0x12.
  - `o_ack[0]` in cycle 6; `o_busy` low by cycle 8.
- Port 1 read, addr 0x05, with `i_sc_din`=0x1234 only in cycle 5:
  - `o_rdata`=0x1234 at `o_ack[1]` in cycle 6; oe never high.
- Both ports request continuously from reset:
  - grants alternate 0,1,0,1, each ack one-hot, 8 cycles apart.
- Port 0 requests back-to-back with TURN_LEN=0:
  - second SETUP in cycle 8 (IDLE in cycle 7).
- Assert `i_reset_n`=0 during cycle 3 of a write:
  - iocyc, oe, ioaddr go 0 immediately and no ack ever appears.
  - After release, a new port 1 request completes normally.
- Port 1 drops `i_req` in cycle 3:
  - transfer completes and `o_ack[1]` still pulses in cycle 6.
  - The next IDLE with no requests stays IDLE.
